// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_search_ctrl
// Brief    : Successive-approximation search controller driving the B operand
//            of a magnitude comparator and binary-searching for its A operand.
// Revision : 1.0 - initial release
// ============================================================================
module sar_search_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_msb = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_lsb = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_trial, w_trial_nxt;
    logic [WIDTH-1:0] r_mask, w_mask_nxt;     // one-hot copy of the bit index
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_err, w_err_nxt;

    logic             w_valid;
    logic [WIDTH-1:0] w_mask_dn;

    assign w_valid = (cmp_gt & ~cmp_eq & ~cmp_lt) |
                     (~cmp_gt & cmp_eq & ~cmp_lt) |
                     (~cmp_gt & ~cmp_eq & cmp_lt);
    assign w_mask_dn = r_mask >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_trial  <= '0;
            r_mask   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_mask   <= w_mask_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_mask_nxt   = r_mask;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        case (r_state)
            S_PROBE: begin
                if (!w_valid) begin
                    w_state_nxt  = S_DONE;
                    w_trial_nxt  = '0;
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b1;
                end else if (cmp_eq) begin
                    w_state_nxt  = S_DONE;
                    w_trial_nxt  = '0;
                    w_result_nxt = r_trial;
                end else if (r_mask[0]) begin
                    // Last bit: lt resolves it to zero, gt contradicts earlier answers
                    w_state_nxt = S_DONE;
                    w_trial_nxt = '0;
                    if (cmp_lt) begin
                        w_result_nxt = r_trial & ~c_lsb;
                    end else begin
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
                    end
                end else if (cmp_gt) begin
                    w_trial_nxt = r_trial | w_mask_dn;
                    w_mask_nxt  = w_mask_dn;
                end else begin
                    w_trial_nxt = (r_trial & ~r_mask) | w_mask_dn;
                    w_mask_nxt  = w_mask_dn;
                end
            end
            default: begin
                w_trial_nxt = '0;
                w_err_nxt   = 1'b0;
                if (start) begin
                    w_state_nxt = S_PROBE;
                    w_trial_nxt = c_msb;
                    w_mask_nxt  = c_msb;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    assign trial  = r_trial;
    assign busy   = (r_state == S_PROBE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_search_ctrl
// Brief    : Self-checking bench: directed scenarios plus randomized searches
//            checked every cycle against a search-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic [W-1:0] trial;
    logic         busy, done, err;
    logic [W-1:0] result;

    int           target = 0;
    int           f_k = -1;          // probe number whose response is overridden
    logic [2:0]   f_resp = 3'b000;   // {gt,eq,lt} override
    logic [2:0]   rsp_drv;
    bit           chk_on = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: search in progress, probe number, outputs
    bit   m_active = 1'b0;
    int   m_k = 0;
    bit   m_done = 1'b0;
    bit   m_err = 1'b0;
    int   m_result = 0;
    int   w_mtr;
    logic [2:0] w_mrsp;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Probe k of a clean search: target's bits above position p, then a 1 at p
    function automatic int exp_trial(input int t, input int k);
        int p;
        p = W - 1 - k;
        return (t / (2 ** (p + 1))) * (2 ** (p + 1)) + 2 ** p;
    endfunction

    function automatic logic [2:0] nat(input int t, input int b);
        if (t > b) return 3'b100;
        if (t == b) return 3'b010;
        return 3'b001;
    endfunction

    always_comb begin
        rsp_drv = (m_active && m_k == f_k) ? f_resp : nat(target, int'(trial));
    end
    assign cmp_gt = rsp_drv[2];
    assign cmp_eq = rsp_drv[1];
    assign cmp_lt = rsp_drv[0];

    always_comb begin
        w_mtr  = exp_trial(target, m_k);
        w_mrsp = (m_k == f_k) ? f_resp : nat(target, w_mtr);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_result <= 0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_active) begin
                if (!(w_mrsp == 3'b100 || w_mrsp == 3'b010 || w_mrsp == 3'b001)) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_err    <= 1'b1;
                    m_result <= 0;
                end else if (w_mrsp == 3'b010) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= w_mtr;
                end else if (m_k == W - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                    if (w_mrsp == 3'b001) begin
                        m_result <= w_mtr - 1;
                    end else begin
                        m_err    <= 1'b1;
                        m_result <= 0;
                    end
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (start) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model trial", int'(trial), m_active ? exp_trial(target, m_k) : 0);
            chk("model busy", int'(busy), int'(m_active));
            chk("model done", int'(done), int'(m_done));
            chk("model err", int'(err), int'(m_err));
            chk("model result", int'(result), m_result);
        end
    end

    // One search with literal expectations; returns at the negedge of the done cycle
    task automatic lit(input string nm, input int tgt, input int n,
                       input int t0, input int t1, input int t2, input int t3,
                       input int eres, input int eerr, input int fk,
                       input logic [2:0] fr, input bit pulse2);
        int tr[4];
        tr = '{t0, t1, t2, t3};
        @(negedge clk);
        target = tgt;
        f_k    = fk;
        f_resp = fr;
        start  = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            start = pulse2 && (i == 2);
            chk({nm, " trial"}, int'(trial), tr[i-1]);
            chk({nm, " busy"}, int'(busy), 1);
            chk({nm, " done early"}, int'(done), 0);
        end
        @(negedge clk);
        start = 1'b0;
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " busy end"}, int'(busy), 0);
        chk({nm, " err"}, int'(err), eerr);
        chk({nm, " result"}, int'(result), eres);
        chk({nm, " trial end"}, int'(trial), 0);
    endtask

    logic [2:0] inv_tab[5];

    initial begin
        inv_tab = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset trial", int'(trial), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;

        lit("t11", 11, 4, 8, 12, 10, 11, 11, 0, -1, 3'b000, 1'b0);
        lit("t8", 8, 1, 8, 0, 0, 0, 8, 0, -1, 3'b000, 1'b0);
        lit("t0", 0, 4, 8, 4, 2, 1, 0, 0, -1, 3'b000, 1'b0);
        lit("t15", 15, 4, 8, 12, 14, 15, 15, 0, -1, 3'b000, 1'b0);
        lit("invalid p2", 11, 2, 8, 12, 0, 0, 0, 1, 1, 3'b101, 1'b0);
        lit("gt idx0", 5, 4, 8, 4, 6, 5, 0, 1, 3, 3'b100, 1'b0);
        lit("start busy", 11, 4, 8, 12, 10, 11, 11, 0, -1, 3'b000, 1'b1);

        // Start accepted in the done cycle
        f_k    = -1;
        target = 3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done-start trial", int'(trial), 8);
        chk("done-start busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("done-start done", int'(done), 1);
        chk("done-start result", int'(result), 3);

        // Reset mid-search
        @(negedge clk);
        target = 11;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst mid busy", int'(busy), 0);
        chk("rst mid trial", int'(trial), 0);
        chk("rst mid result", int'(result), 0);
        chk("rst mid done", int'(done), 0);
        @(negedge clk);
        chk("rst no done", int'(done), 0);
        rst_n = 1'b1;
        lit("after rst", 11, 4, 8, 12, 10, 11, 11, 0, -1, 3'b000, 1'b0);

        // Randomized traffic, checked cycle by cycle against the model
        repeat (3000) begin
            @(negedge clk);
            if (!m_active) begin
                int r;
                target = int'($urandom_range(0, 15));
                r = int'($urandom % 8);
                if (r == 0) begin
                    f_k    = int'($urandom_range(0, W - 1));
                    f_resp = inv_tab[$urandom % 5];
                end else if (r == 1) begin
                    f_k    = W - 1;
                    f_resp = 3'b100;
                end else begin
                    f_k = -1;
                end
            end
            start = ($urandom % 3 == 0);
            if ($urandom % 200 == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
